// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the register bank: alternates between two requesters
// and sequences a one-register-per-cycle bulk clear.
//
// state | meaning
// IDLE  | accepting writes from req0/req1
// CLEAR | writing zero to register cnt, one register per cycle
module reg_write_arbiter #(
    parameter int NREG = 4,
    parameter int DW   = 4,
    parameter int AW   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,
    input  logic            clr_start,
    output logic [NREG-1:0] load,
    output logic [DW-1:0]   d,
    output logic            busy,
    output logic            clr_done,
    output logic            err_addr
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] load_q, load_d;
    logic [DW-1:0]   d_q, d_d;
    logic            busy_q, busy_d;
    logic            clr_done_q, clr_done_d;
    logic            err_addr_q, err_addr_d;

    logic            xfer0, xfer1;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    // ptr_q selects which requester wins when both are valid.
    assign req0_ready = !reset && (state_q == IDLE) && !clr_start
                        && (!req1_valid || (ptr_q == 1'b0));
    assign req1_ready = !reset && (state_q == IDLE) && !clr_start
                        && (!req0_valid || (ptr_q == 1'b1));

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        load_d     = '0;
        d_d        = d_q;
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
        err_addr_d = 1'b0;
        wr_addr    = xfer0 ? req0_addr : req1_addr;
        wr_data    = xfer0 ? req0_data : req1_data;

        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    load_d     = NREG'(1);
                    d_d        = '0;
                    busy_d     = 1'b1;
                    clr_done_d = (NREG == 1);
                end else if (xfer0 || xfer1) begin
                    ptr_d = xfer0;
                    // Out-of-range writes are consumed but never reach the bank.
                    if ({{(32-AW){1'b0}}, wr_addr} < 32'(NREG)) begin
                        load_d = NREG'(1) << wr_addr;
                        d_d    = wr_data;
                    end else begin
                        err_addr_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + AW'(1);
                    load_d     = NREG'(1) << cnt_d;
                    d_d        = '0;
                    busy_d     = 1'b1;
                    clr_done_d = (cnt_d == CNT_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            load_q     <= '0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign load     = load_q;
    assign d        = d_q;
    assign busy     = busy_q;
    assign clr_done = clr_done_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: scoreboard of per-cycle expected outputs for the
// 4-register instance, plus directed checks on a 3-register instance.
module tb_reg_write_arbiter;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, clr_start = 1'b0;
    logic [1:0] req0_addr = '0, req1_addr = '0;
    logic [3:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, busy, clr_done, err_addr;
    logic [3:0] load, d;

    logic       v3 = 1'b0;
    logic [1:0] a3 = '0;
    logic [3:0] d3_in = '0;
    logic       r3_0, r3_1, busy3, done3, err3;
    logic [2:0] load3;
    logic [3:0] d3;

    reg_write_arbiter #(.NREG(4), .DW(4), .AW(2)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_start(clr_start), .load(load), .d(d), .busy(busy), .clr_done(clr_done), .err_addr(err_addr)
    );

    reg_write_arbiter #(.NREG(3), .DW(4), .AW(2)) u_dut3 (
        .clock(clock), .reset(reset),
        .req0_valid(v3), .req0_addr(a3), .req0_data(d3_in), .req0_ready(r3_0),
        .req1_valid(1'b0), .req1_addr(2'b00), .req1_data(4'h0), .req1_ready(r3_1),
        .clr_start(1'b0), .load(load3), .d(d3), .busy(busy3), .clr_done(done3), .err_addr(err3)
    );

    typedef struct packed {
        logic [3:0] load;
        logic [3:0] d;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_ptr = 1'b0;
    logic [3:0] m_d = '0;
    logic       acc0 = 1'b0, acc1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [3:0] l, logic [3:0] dd, logic b, logic c, logic e);
        exp_t x;
        x.load = l; x.d = dd; x.busy = b; x.done = c; x.err = e;
        return x;
    endfunction

    // Per-cycle model: compare this cycle's outputs, then predict next cycle's.
    always @(negedge clock) begin
        exp_t e;
        logic er0, er1;
        e = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("load", 32'(load), 32'(e.load));
            check("d", 32'(d), 32'(e.d));
            check("busy", 32'(busy), 32'(e.busy));
            check("clr_done", 32'(clr_done), 32'(e.done));
            check("err_addr", 32'(err_addr), 32'(e.err));
        end
        er0 = !reset && !e.busy && !clr_start && (!req1_valid || !m_ptr);
        er1 = !reset && !e.busy && !clr_start && (!req0_valid || m_ptr);
        check("ready0", 32'(req0_ready), 32'(er0));
        check("ready1", 32'(req1_ready), 32'(er1));
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;

        if (reset) begin
            sb.delete();
            sb.push_back('0);
            m_ptr = 1'b0;
            m_d   = '0;
        end else if (e.busy) begin
            if (sb.size() == 0) sb.push_back(mk(4'h0, m_d, 1'b0, 1'b0, 1'b0));
        end else if (clr_start) begin
            for (int i = 0; i < 4; i++)
                sb.push_back(mk(4'(1 << i), 4'h0, 1'b1, (i == 3), 1'b0));
            m_d = '0;
        end else if (req0_valid && er0) begin
            sb.push_back(mk(4'(1 << req0_addr), req0_data, 1'b0, 1'b0, 1'b0));
            m_d   = req0_data;
            m_ptr = 1'b1;
        end else if (req1_valid && er1) begin
            sb.push_back(mk(4'(1 << req1_addr), req1_data, 1'b0, 1'b0, 1'b0));
            m_d   = req1_data;
            m_ptr = 1'b0;
        end else begin
            sb.push_back(mk(4'h0, m_d, 1'b0, 1'b0, 1'b0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // reset with both valids high
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clock);
        check("t1_ready0_rst", 32'(req0_ready), 32'd0);
        check("t1_ready1_rst", 32'(req1_ready), 32'd0);
        cyc(2);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        check("t1_load", 32'(load), 32'h0);
        check("t1_busy", 32'(busy), 32'd0);
        cyc(2);

        // single req0 write
        req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 4'hA;
        @(negedge clock);
        check("t2_ready0", 32'(req0_ready), 32'd1);
        cyc(1);
        req0_valid = 1'b0;
        @(negedge clock);
        check("t2_load", 32'(load), 32'b0100);
        check("t2_d", 32'(d), 32'hA);
        cyc(1);
        @(negedge clock);
        check("t2_load_off", 32'(load), 32'h0);
        cyc(1);

        // req1 write hands priority back to req0
        req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 4'h6;
        cyc(1);
        req1_valid = 1'b0;
        cyc(2);

        // contention: strict alternation
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 4'h3;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 4'h5;
        cyc(1);
        @(negedge clock);
        check("t3_load_a", 32'(load), 32'b0010);
        check("t3_d_a", 32'(d), 32'h3);
        cyc(1);
        @(negedge clock);
        check("t3_load_b", 32'(load), 32'b1000);
        check("t3_d_b", 32'(d), 32'h5);
        cyc(2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(2);

        // bulk clear with req1 waiting; second clr_start mid-clear is ignored
        req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 4'h7; clr_start = 1'b1;
        @(negedge clock);
        check("t4_ready1_t", 32'(req1_ready), 32'd0);
        cyc(1);
        clr_start = 1'b0;
        @(negedge clock);
        check("t4_load_0", 32'(load), 32'b0001);
        check("t4_busy", 32'(busy), 32'd1);
        cyc(1);
        clr_start = 1'b1;
        cyc(1);
        clr_start = 1'b0;
        cyc(1);
        @(negedge clock);
        check("t4_load_3", 32'(load), 32'b1000);
        check("t4_done", 32'(clr_done), 32'd1);
        check("t4_ready1_last", 32'(req1_ready), 32'd0);
        cyc(1);
        @(negedge clock);
        check("t4_ready1_after", 32'(req1_ready), 32'd1);
        check("t4_busy_after", 32'(busy), 32'd0);
        cyc(1);
        req1_valid = 1'b0;
        @(negedge clock);
        check("t4_load_req1", 32'(load), 32'b0001);
        check("t4_d_req1", 32'(d), 32'h7);
        cyc(2);

        // reset aborts a clear
        clr_start = 1'b1;
        cyc(1);
        clr_start = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clock);
        check("t5_load", 32'(load), 32'h0);
        check("t5_busy", 32'(busy), 32'd0);
        cyc(1);
        @(negedge clock);
        check("t5_no_resume", 32'(load), 32'h0);
        cyc(3);

        // random traffic; requesters hold until accepted
        for (int n = 0; n < 300; n++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 2'($urandom_range(0, 3));
                req0_data  = 4'($urandom_range(0, 15));
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 2'($urandom_range(0, 3));
                req1_data  = 4'($urandom_range(0, 15));
            end
            clr_start = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        reset = 1'b0; clr_start = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(6);

        // NREG=3: out-of-range address is accepted and dropped
        v3 = 1'b1; a3 = 2'd3; d3_in = 4'hF;
        @(negedge clock);
        check("t6_ready0", 32'(r3_0), 32'd1);
        cyc(1);
        v3 = 1'b0;
        @(negedge clock);
        check("t6_load", 32'(load3), 32'b000);
        check("t6_err", 32'(err3), 32'd1);
        cyc(1);
        v3 = 1'b1; a3 = 2'd2; d3_in = 4'h5;
        cyc(1);
        v3 = 1'b0;
        @(negedge clock);
        check("t6_load_ok", 32'(load3), 32'b100);
        check("t6_d_ok", 32'(d3), 32'h5);
        check("t6_err_ok", 32'(err3), 32'd0);
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
